// File: rtl/iob_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_bus_arbiter : grant-until-ready arbiter sharing one native-bus slave.
// Rev 1.0 -- define ARB_ROUND_ROBIN_EN for rotating priority, else fixed.
// ---------------------------------------------------------------------------
module iob_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic                            s_ready,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [N_MASTERS-1:0]            grant
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [N_MASTERS-1:0] LSB_ONE = N_MASTERS'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [N_MASTERS-1:0] grant_d;
  logic [N_MASTERS-1:0] winner;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_wstrb;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_d;
  logic [PTR_W-1:0]     gidx;
  logic [N_MASTERS-1:0] rot_req;
  logic [N_MASTERS-1:0] rot_pri;

  // Rotate requests so the pointer sits at bit 0, isolate the lowest set
  // bit, then rotate the single winner back into place.
  always_comb begin
    rot_req = N_MASTERS'({m_valid, m_valid} >> ptr);
    rot_pri = rot_req & (~rot_req + LSB_ONE);
    winner  = N_MASTERS'(({rot_pri, rot_pri} << ptr) >> N_MASTERS);
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_d;
  end
`else
  always_comb begin
    winner = m_valid & (~m_valid + LSB_ONE);
  end
`endif

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr;
`endif
    m_ready = '0;
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    case (state)
      IDLE: begin
        if (|m_valid) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Grant is held even if the owner drops valid early; only s_ready frees it.
        s_valid = |(m_valid & grant);
        s_addr  = sel_addr;
        s_wdata = sel_wdata;
        s_wstrb = sel_wstrb;
        if (s_ready) begin
          m_ready = grant;
          grant_d = '0;
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = (gidx == PTR_W'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign m_rdata = s_rdata;

endmodule
`default_nettype wire

// File: tb/tb_iob_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iob_bus_arbiter : directed scoreboard bench for iob_bus_arbiter (2 masters).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_iob_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready;
  logic [DW-1:0]   s_rdata;
  logic [N-1:0]    grant;

  iob_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } exp_t;

  req_t mq0[$];
  req_t mq1[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   slave_lat = 1;
  bit   slave_en = 1'b1;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid != '0 || mq0.size() != 0 || mq1.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: timeout, pending=%0d required=0", name, exp_q.size());
    end
    @(negedge clk);
  endtask

  // Slave model: answers after slave_lat cycles of s_valid.
  initial begin : slave
    logic        sv;
    logic [31:0] sa;
    int          cnt;
    cnt = 0; sv = 1'b0; sa = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      sv = s_valid;
      sa = s_addr;
      @(posedge clk);
      #1;
      if (!rst) begin
        cnt = 0;
        s_ready = 1'b0;
      end else if (slave_en) begin
        if (s_ready) begin
          s_ready = 1'b0;
          cnt = 0;
        end else if (sv) begin
          cnt++;
          if (cnt >= slave_lat) begin
            s_ready = 1'b1;
            s_rdata = rd_of(sa);
            cnt = 0;
          end
        end
      end
    end
  end

  // Master drivers: hold a request until m_ready, then load the next one.
  initial begin : drv
    logic [N-1:0] rdy;
    req_t         r;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    forever begin
      @(negedge clk);
      rdy = m_ready;
      @(posedge clk);
      #1;
      if (rdy[0]) m_valid[0] = 1'b0;
      if (rdy[1]) m_valid[1] = 1'b0;
      if (!m_valid[0] && mq0.size() > 0) begin
        r = mq0.pop_front();
        m_addr[0 +: AW] = r.addr; m_wdata[0 +: DW] = r.wdata; m_wstrb[0 +: SW] = r.wstrb;
        m_valid[0] = 1'b1;
      end
      if (!m_valid[1] && mq1.size() > 0) begin
        r = mq1.pop_front();
        m_addr[AW +: AW] = r.addr; m_wdata[DW +: DW] = r.wdata; m_wstrb[SW +: SW] = r.wstrb;
        m_valid[1] = 1'b1;
      end
    end
  end

  // Monitor: every m_ready pulse must match the next expected completion.
  initial begin : mon
    exp_t         e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (m_ready !== '0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_m_ready: actual=%b required=00", m_ready);
        end else begin
          e  = exp_q.pop_front();
          oh = 2'b01 << e.who;
          check("m_ready_owner", 64'(m_ready), 64'(oh));
          check("m_rdata", 64'(m_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant",   64'(grant),   64'(0));
    check("rst_s_valid", 64'(s_valid), 64'(0));
    check("rst_s_addr",  64'(s_addr),  64'(0));
    check("rst_s_wdata", 64'(s_wdata), 64'(0));
    check("rst_s_wstrb", 64'(s_wstrb), 64'(0));
    check("rst_m_ready", 64'(m_ready), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single master read
    exp_q.push_back('{who: 2'd1, data: 32'hDEADBEEF});
    mq1.push_back('{addr: 32'h100, wdata: 32'h0, wstrb: 4'h0});
    repeat (2) @(negedge clk);
    check("t1_grant",   64'(grant),   64'(2'b10));
    check("t1_s_valid", 64'(s_valid), 64'(1));
    check("t1_s_addr",  64'(s_addr),  64'(32'h100));
    repeat (2) @(negedge clk);
    check("t1_idle_s_valid", 64'(s_valid), 64'(0));
    check("t1_idle_s_addr",  64'(s_addr),  64'(0));
    check("t1_idle_grant",   64'(grant),   64'(0));
    wait_drain("t1_drain", 40);

    // Contention, three requests per master
    for (int i = 0; i < 3; i++) begin
      mq0.push_back('{addr: 32'h1000 + 32'(4*i), wdata: 32'hA0 + 32'(i), wstrb: (i == 1) ? 4'h3 : 4'h0});
      mq1.push_back('{addr: 32'h2000 + 32'(4*i), wdata: 32'hB0 + 32'(i), wstrb: 4'h0});
    end
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{who: 2'd0, data: rd_of(32'h1000 + 32'(4*i))});
      exp_q.push_back('{who: 2'd1, data: rd_of(32'h2000 + 32'(4*i))});
    end
`else
    for (int i = 0; i < 3; i++) exp_q.push_back('{who: 2'd0, data: rd_of(32'h1000 + 32'(4*i))});
    for (int i = 0; i < 3; i++) exp_q.push_back('{who: 2'd1, data: rd_of(32'h2000 + 32'(4*i))});
`endif
    wait_drain("t2_drain", 80);

    // Write routing from master 1
    exp_q.push_back('{who: 2'd1, data: rd_of(32'h200)});
    mq1.push_back('{addr: 32'h200, wdata: 32'h12345678, wstrb: 4'hF});
    repeat (2) @(negedge clk);
    check("t3_grant",   64'(grant),   64'(2'b10));
    check("t3_s_addr",  64'(s_addr),  64'(32'h200));
    check("t3_s_wdata", 64'(s_wdata), 64'(32'h12345678));
    check("t3_s_wstrb", 64'(s_wstrb), 64'(4'hF));
    wait_drain("t3_drain", 40);

    // Slow slave: grant held through the wait, then bubble, then master 1
    slave_lat = 5;
    exp_q.push_back('{who: 2'd0, data: rd_of(32'h300)});
    exp_q.push_back('{who: 2'd1, data: rd_of(32'h400)});
    mq0.push_back('{addr: 32'h300, wdata: 32'h0, wstrb: 4'h0});
    mq1.push_back('{addr: 32'h400, wdata: 32'hCAFE, wstrb: 4'h1});
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_grant", 64'(grant), 64'(2'b01));
      @(negedge clk);
    end
    @(negedge clk);
    check("t4_bubble_grant", 64'(grant), 64'(2'b00));
    @(negedge clk);
    check("t4_next_grant", 64'(grant), 64'(2'b10));
    wait_drain("t4_drain", 60);
    slave_lat = 1;

    // Reset mid-transaction
    exp_q.push_back('{who: 2'd0, data: rd_of(32'h500)});
    mq0.push_back('{addr: 32'h500, wdata: 32'h0, wstrb: 4'h0});
    wait_drain("t5_pre_drain", 40);
    slave_lat = 5;
    mq1.push_back('{addr: 32'h600, wdata: 32'h0, wstrb: 4'h0});
    repeat (2) @(negedge clk);
    check("t5_busy_grant", 64'(grant), 64'(2'b10));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_s_valid", 64'(s_valid), 64'(0));
    check("t5_rst_grant",   64'(grant),   64'(0));
    check("t5_rst_m_ready", 64'(m_ready), 64'(0));
    m_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    slave_lat = 1;
    @(negedge clk);
    exp_q.push_back('{who: 2'd0, data: rd_of(32'h700)});
    exp_q.push_back('{who: 2'd1, data: rd_of(32'h800)});
    mq0.push_back('{addr: 32'h700, wdata: 32'h0, wstrb: 4'h0});
    mq1.push_back('{addr: 32'h800, wdata: 32'h0, wstrb: 4'h0});
    repeat (2) @(negedge clk);
    check("t5_first_grant", 64'(grant), 64'(2'b01));
    wait_drain("t5_drain", 40);

    // Spurious s_ready while idle
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    s_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("t6_m_ready", 64'(m_ready), 64'(0));
    check("t6_grant",   64'(grant),   64'(0));
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    @(negedge clk);
    check("t6_after_grant",   64'(grant),   64'(0));
    check("t6_after_s_valid", 64'(s_valid), 64'(0));
    slave_en = 1'b1;

    check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
